// File: rtl/cardinal_nic_if.sv
// Processor register port plus ring-router channel of the cardinal NIC.
// The slave modport is the NIC's view; master is the processor/router side.
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;

  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    output d_out,
    input  net_si, net_di, net_ro, net_polarity,
    output net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    input  d_out,
    output net_si, net_di, net_ro, net_polarity,
    input  net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic.sv
// Cardinal NIC: single-entry input/output channel buffers between the core's
// memory-mapped port and the ring router. Packet bit 0 (MSB) is the VC bit.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  cardinal_nic_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] A_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_IN_STS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_STS = ADDR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic                  in_full_q, in_full_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  out_full_q, out_full_d;

  logic rd_en, wr_en;
  logic in_take, in_clr, out_load, send;

  assign rd_en = bus.nicEn & ~bus.nicWrEn;
  assign wr_en = bus.nicEn &  bus.nicWrEn;

  // All decisions use pre-edge state, so capture and drain of one buffer
  // can never coincide (they require opposite full flags).
  assign in_take  = bus.net_si & ~in_full_q;
  assign in_clr   = rd_en & (bus.addr == A_IN_BUF) & in_full_q;
  assign out_load = wr_en & (bus.addr == A_OUT_BUF) & ~out_full_q;
  assign send     = out_full_q & bus.net_ro
                  & (out_buf_q[DATA_WIDTH-1] == bus.net_polarity);

  assign bus.net_ri = ~in_full_q;
  assign bus.net_so = send;
  assign bus.net_do = out_buf_q;

  always_comb begin
    bus.d_out = '0;
    if (rd_en) begin
      case (bus.addr)
        A_IN_BUF:  bus.d_out = in_buf_q;
        A_IN_STS:  bus.d_out = DATA_WIDTH'(in_full_q);
        A_OUT_BUF: bus.d_out = out_buf_q;
        A_OUT_STS: bus.d_out = DATA_WIDTH'(out_full_q);
        default:   bus.d_out = '0;
      endcase
    end
  end

  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    if (in_take) begin
      in_buf_d  = bus.net_di;
      in_full_d = 1'b1;
    end else if (in_clr) begin
      in_full_d = 1'b0;
    end
  end

  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (send) begin
      out_full_d = 1'b0;
    end else if (out_load) begin
      out_buf_d  = bus.d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboarded random/directed bench for cardinal_nic against a packet-level model.
module tb_cardinal_nic;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cardinal_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) nic_if ();

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (nic_if)
  );

  typedef struct packed {
    logic        ri;
    logic        so;
    logic [63:0] dov;
    logic [63:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sends    = 0;

  // Model: how many packets each channel holds (0 or 1) and the last value
  // written into each buffer register (reads see it even when empty).
  int          in_cnt, out_cnt;
  logic [63:0] in_last, out_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("net_ri", 64'(nic_if.net_ri), 64'(e.ri));
      chk("net_so", 64'(nic_if.net_so), 64'(e.so));
      chk("net_do", nic_if.net_do, e.dov);
      chk("d_out",  nic_if.d_out,  e.dout);
      if (nic_if.net_so === 1'b1) sends++;
    end
  end

  task automatic step(input bit r, input bit en, input bit wr, input logic [1:0] a,
                      input logic [63:0] din, input bit si, input logic [63:0] di,
                      input bit ro, input bit pol, input bit do_chk = 1'b1);
    exp_t e;
    bit   rd0, wr2, so;
    rst = r;
    nic_if.nicEn = en; nic_if.nicWrEn = wr; nic_if.addr = a; nic_if.d_in = din;
    nic_if.net_si = si; nic_if.net_di = di; nic_if.net_ro = ro; nic_if.net_polarity = pol;
    so = (out_cnt == 1) && ro && (out_last[63] == pol);
    e.ri   = (in_cnt == 0);
    e.so   = so;
    e.dov  = out_last;
    e.dout = '0;
    if (en && !wr) begin
      case (a)
        2'd0: e.dout = in_last;
        2'd1: e.dout = 64'(in_cnt);
        2'd2: e.dout = out_last;
        default: e.dout = 64'(out_cnt);
      endcase
    end
    if (do_chk) exp_q.push_back(e);
    @(posedge clk);
    rd0 = en && !wr && (a == 2'd0);
    wr2 = en && wr && (a == 2'd2);
    if (r) begin
      in_cnt = 0; out_cnt = 0; in_last = '0; out_last = '0;
    end else begin
      if (si && in_cnt == 0) begin
        in_last = di; in_cnt = 1;
      end else if (rd0) in_cnt = 0;
      if (so) out_cnt = 0;
      else if (wr2 && out_cnt == 0) begin
        out_last = din; out_cnt = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ro = 1'b0, input bit pol = 1'b0);
    step(0, 0, 0, 2'd0, '0, 0, '0, ro, pol);
  endtask

  task automatic rd(input logic [1:0] a, input bit si = 1'b0, input logic [63:0] di = '0);
    step(0, 1, 0, a, '0, si, di, 0, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d, input bit ro = 1'b0, input bit pol = 1'b0);
    step(0, 1, 1, a, d, 0, '0, ro, pol);
  endtask

  initial begin
    in_cnt = 0; out_cnt = 0; in_last = '0; out_last = '0;
    // First reset cycle: DUT registers are still unknown before the edge.
    step(1, 0, 0, 2'd0, '0, 0, '0, 0, 0, 1'b0);
    repeat (4) step(1, 0, 0, 2'd0, '0, 0, '0, 0, 0);
    rd(2'd1);
    rd(2'd3);

    // Router to processor
    step(0, 0, 0, 2'd0, '0, 1, 64'h0000_0001_DEAD_BEEF, 0, 0);
    rd(2'd1);
    rd(2'd0);
    rd(2'd1);
    rd(2'd0);

    // Processor to router, gated by polarity
    wr(2'd2, 64'h8000_0000_1234_5678, 1, 0);
    idle(1, 0);
    idle(1, 1);
    rd(2'd3);

    // Backpressure and dropped second write
    wr(2'd2, 64'h0123_4567_89AB_CDEF, 0, 1);
    idle(0, 0);
    wr(2'd2, 64'h0000_0000_0000_FFFF, 0, 1);
    idle(0, 1);
    idle(0, 0);
    rd(2'd2);
    rd(2'd3);
    wr(2'd2, 64'h0000_0000_0000_1111, 1, 0);
    rd(2'd3);

    // Read-clear and arriving packet in the same cycle
    step(0, 0, 0, 2'd0, '0, 1, 64'hAAAA_0000_0000_0001, 0, 0);
    rd(2'd0, 1, 64'hBBBB_0000_0000_0002);
    rd(2'd1, 1, 64'hBBBB_0000_0000_0002);
    rd(2'd0);
    wr(2'd0, 64'h1);
    wr(2'd1, 64'h1);
    wr(2'd3, 64'h1);
    rd(2'd1);

    // Reset with both buffers full
    step(0, 1, 1, 2'd2, 64'h8765_4321_0000_0000, 1, 64'hCCCC_0000_0000_0003, 0, 0);
    step(1, 0, 0, 2'd0, '0, 0, '0, 1, 1);
    idle(1, 0);
    rd(2'd1);
    rd(2'd3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit   r, en, w, si, ro, pol;
      logic [1:0] a;
      r   = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      w   = $urandom_range(0, 1);
      a   = 2'($urandom_range(0, 3));
      if (en && w && $urandom_range(0, 1)) a = 2'd2;
      si  = ($urandom_range(0, 2) == 0);
      ro  = ($urandom_range(0, 3) != 0);
      pol = $urandom_range(0, 1);
      step(r, en, w, a, {$urandom, $urandom}, si, {$urandom, $urandom}, ro, pol);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    if (sends == 0) begin
      failures++;
      $display("FAIL no_injections actual=0 required>0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
